// File: rtl/jpeg_seq_pkg.sv
// Shared types for the JPEG block sequencer: FSM states, component ids and
// the per-MCU component schedules for 4:4:4 and 4:2:0 layouts.
package jpeg_seq_pkg;

    typedef enum logic [2:0] {
        ST_FILL,
        ST_DCT_GO,
        ST_DCT_WAIT,
        ST_DCT_END,
        ST_QUANT,
        ST_ZIGZAG,
        ST_HUFF_GO,
        ST_HUFF_WAIT
    } seq_state_t;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam int BLOCKS_444 = 3;
    localparam int BLOCKS_420 = 6;

    // Tables are packed two bits per block, block 0 in the least significant slot.
    localparam logic [5:0]  SCHED_444 = {COMP_CR, COMP_CB, COMP_Y};
    localparam logic [11:0] SCHED_420 = {COMP_CR, COMP_CB, COMP_Y, COMP_Y, COMP_Y, COMP_Y};

endpackage

// File: rtl/jpeg_mcu_schedule.sv
// Maps the MCU layout and block index to the component being coded and
// flags the final block of the MCU.
module jpeg_mcu_schedule
    import jpeg_seq_pkg::*;
(
    input  logic       mode_420,
    input  logic [2:0] block_idx,
    output logic [1:0] comp_id,
    output logic       last_block
);

    logic [3:0] sel;

    assign sel = {block_idx, 1'b0};

    always_comb begin
        comp_id    = COMP_Y;
        last_block = 1'b0;
        if (mode_420) begin
            if (block_idx < 3'(BLOCKS_420)) begin
                comp_id = SCHED_420[sel +: 2];
            end
            last_block = (block_idx == 3'(BLOCKS_420 - 1));
        end else begin
            if (block_idx < 3'(BLOCKS_444)) begin
                comp_id = SCHED_444[sel +: 2];
            end
            last_block = (block_idx == 3'(BLOCKS_444 - 1));
        end
    end

endmodule

// File: rtl/jpeg_block_sequencer.sv
// Sequences one 8x8 block at a time through fill, DCT, quantisation, zigzag
// and Huffman stages, walking the MCU component schedule between blocks.
module jpeg_block_sequencer
    import jpeg_seq_pkg::*;
#(
    parameter int PIX_WIDTH    = 12,
    parameter int DCT_LAT      = 4,
    parameter int QUANT_LAT    = 2,
    parameter int HUFF_TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [PIX_WIDTH-1:0] pix_data,
    input  logic                 mode_420,
    input  logic                 abort,
    input  logic                 huffman_done,
    output logic                 input_1pix_enable,
    output logic [PIX_WIDTH-1:0] pix_1pix_data,
    output logic                 dct_enable,
    output logic                 dct_end_enable,
    output logic                 zigzag_input_enable,
    output logic                 zigzag_enable,
    output logic [7:0]           matrix_row,
    output logic                 huffman_start,
    output logic                 is_luminance,
    output logic [1:0]           comp_id,
    output logic                 busy,
    output logic                 mcu_done,
    output logic                 err_timeout
);

    localparam int HW = $clog2(HUFF_TIMEOUT + 1);

    seq_state_t    state, state_next;
    logic [5:0]    pix_cnt;
    logic [7:0]    dct_cnt;
    logic [2:0]    row;
    logic [3:0]    row_cnt;
    logic [HW-1:0] huff_cnt;
    logic [2:0]    block_idx;
    logic          mode_q;
    logic          last_block;
    logic          accept;
    logic          dct_last;
    logic          row_last;
    logic          huff_expired;
    logic          block_complete;

    jpeg_mcu_schedule u_schedule (
        .mode_420   (mode_q),
        .block_idx  (block_idx),
        .comp_id    (comp_id),
        .last_block (last_block)
    );

    // Ready is held low while reset is active so no pixel strobe can leak out.
    assign pix_ready         = (state == ST_FILL) && !abort && reset_n;
    assign accept            = pix_valid && pix_ready;
    assign input_1pix_enable = accept;
    assign pix_1pix_data     = pix_data;

    assign dct_last       = (dct_cnt == 8'(DCT_LAT - 1));
    assign row_last       = (row_cnt == 4'(QUANT_LAT - 1));
    assign huff_expired   = (huff_cnt == HW'(HUFF_TIMEOUT - 1));
    assign block_complete = (state == ST_HUFF_WAIT) && !abort && (huffman_done || huff_expired);

    assign mcu_done     = block_complete && last_block;
    assign busy         = !((state == ST_FILL) && (pix_cnt == 6'd0));
    assign is_luminance = (comp_id == COMP_Y);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FILL;
        end else if (abort) begin
            state <= ST_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next          = state;
        dct_enable          = 1'b0;
        dct_end_enable      = 1'b0;
        zigzag_input_enable = 1'b0;
        zigzag_enable       = 1'b0;
        huffman_start       = 1'b0;
        matrix_row          = 8'd0;
        case (state)
            ST_FILL: begin
                if (accept && (pix_cnt == 6'd63)) state_next = ST_DCT_GO;
            end
            ST_DCT_GO: begin
                dct_enable = 1'b1;
                state_next = ST_DCT_WAIT;
            end
            ST_DCT_WAIT: begin
                if (dct_last) state_next = ST_DCT_END;
            end
            ST_DCT_END: begin
                dct_end_enable = 1'b1;
                state_next     = ST_QUANT;
            end
            ST_QUANT: begin
                matrix_row          = {5'd0, row};
                zigzag_input_enable = row_last;
                if (row_last && (row == 3'd7)) state_next = ST_ZIGZAG;
            end
            ST_ZIGZAG: begin
                zigzag_enable = 1'b1;
                state_next    = ST_HUFF_GO;
            end
            ST_HUFF_GO: begin
                huffman_start = 1'b1;
                state_next    = ST_HUFF_WAIT;
            end
            ST_HUFF_WAIT: begin
                if (block_complete) state_next = ST_FILL;
            end
            default: state_next = ST_FILL;
        endcase
        // An abort cycle is silent on every datapath strobe.
        if (abort) begin
            dct_enable          = 1'b0;
            dct_end_enable      = 1'b0;
            zigzag_input_enable = 1'b0;
            zigzag_enable       = 1'b0;
            huffman_start       = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pix_cnt     <= '0;
            dct_cnt     <= '0;
            row         <= '0;
            row_cnt     <= '0;
            huff_cnt    <= '0;
            block_idx   <= '0;
            mode_q      <= 1'b0;
            err_timeout <= 1'b0;
        end else if (abort) begin
            pix_cnt   <= '0;
            dct_cnt   <= '0;
            row       <= '0;
            row_cnt   <= '0;
            huff_cnt  <= '0;
            block_idx <= '0;
        end else begin
            if (accept) begin
                pix_cnt <= pix_cnt + 6'd1;
                // Layout is latched only when an MCU begins so it cannot change mid-MCU.
                if ((pix_cnt == 6'd0) && (block_idx == 3'd0)) mode_q <= mode_420;
            end
            if (state == ST_DCT_WAIT) begin
                dct_cnt <= dct_last ? 8'd0 : dct_cnt + 8'd1;
            end
            if (state == ST_QUANT) begin
                if (row_last) begin
                    row_cnt <= 4'd0;
                    row     <= row + 3'd1;
                end else begin
                    row_cnt <= row_cnt + 4'd1;
                end
            end
            if (state == ST_HUFF_WAIT) begin
                if (block_complete) begin
                    huff_cnt  <= '0;
                    block_idx <= last_block ? 3'd0 : block_idx + 3'd1;
                    if (!huffman_done) err_timeout <= 1'b1;
                end else begin
                    huff_cnt <= huff_cnt + HW'(1);
                end
            end
        end
    end

endmodule

// File: doc/jpeg_block_sequencer.md
JPEG_BLOCK_SEQUENCER -- requirements
Module: jpeg_block_sequencer

Interface
REQ-001 SHALL have parameter PIX_WIDTH, default 12, pixel sample width.
REQ-002 SHALL have parameter DCT_LAT, default 4, idle cycles between dct_enable and dct_end_enable (range 1..255).
REQ-003 SHALL have parameter QUANT_LAT, default 2, cycles matrix_row is held per row (range 1..15).
REQ-004 SHALL have parameter HUFF_TIMEOUT, default 1024, maximum HUFF_WAIT cycles.
REQ-005 SHALL have ports: clock in 1 system clock; reset_n in 1 asynchronous active-low reset.
REQ-006 SHALL have ports: pix_valid in 1 pixel offered; pix_ready out 1 pixel accepted this cycle if valid; pix_data in PIX_WIDTH pixel sample, row-major.
REQ-007 SHALL have ports: mode_420 in 1 MCU layout select; abort in 1 synchronous flush; huffman_done in 1 Huffman block end.
REQ-008 SHALL have ports: input_1pix_enable out 1; pix_1pix_data out PIX_WIDTH; dct_enable out 1; dct_end_enable out 1; zigzag_input_enable out 1; zigzag_enable out 1; matrix_row out 8; huffman_start out 1 (datapath strobes).
REQ-009 SHALL have ports: is_luminance out 1; comp_id out 2 (0=Y,1=Cb,2=Cr); busy out 1; mcu_done out 1; err_timeout out 1 sticky.

Function
REQ-010 SHALL run FSM states FILL, DCT_GO, DCT_WAIT, DCT_END, QUANT, ZIGZAG, HUFF_GO, HUFF_WAIT.
REQ-011 FILL: pix_ready = ~abort; input_1pix_enable = pix_valid & pix_ready (combinational); pix_1pix_data = pix_data; 6-bit counter increments per accept; 64th accept -> DCT_GO.
REQ-012 DCT_GO: dct_enable high one cycle -> DCT_WAIT for exactly DCT_LAT cycles -> DCT_END: dct_end_enable high one cycle -> QUANT.
REQ-013 QUANT: matrix_row = r for QUANT_LAT cycles, r = 0..7; zigzag_input_enable high on last cycle of each row; after row 7 -> ZIGZAG.
REQ-014 ZIGZAG: zigzag_enable one cycle -> HUFF_GO: huffman_start one cycle -> HUFF_WAIT.
REQ-015 HUFF_WAIT: huffman_done -> block complete, next FILL; huffman_done in any other state ignored.
REQ-016 HUFF_WAIT exceeding HUFF_TIMEOUT cycles SHALL set err_timeout and complete the block as if done.
REQ-017 MCU schedule: mode_420=0 -> Y,Cb,Cr; mode_420=1 -> Y,Y,Y,Y,Cb,Cr; mode_420 sampled at first accept of block 0 only, ignored mid-MCU.
REQ-018 comp_id/is_luminance SHALL be constant from first accept of a block through its HUFF_WAIT; is_luminance = (comp_id==0).
REQ-019 mcu_done SHALL pulse one cycle with completion of the last block of an MCU; block index wraps to 0.
REQ-020 busy = 1 in every state except FILL with pixel counter 0.
REQ-021 abort SHALL, in any state, return to FILL with pixel counter, row counter, block index cleared next cycle; no strobe in abort cycle; abort beats pix_valid; err_timeout unaffected.
REQ-022 matrix_row SHALL be 0 outside QUANT; all strobes low unless stated.
REQ-023 pix_valid gaps in FILL SHALL stall the counter without error.

Reset
REQ-024 reset_n low SHALL asynchronously force FILL, counters 0, block index 0, all strobes 0, matrix_row 0, comp_id 0, is_luminance 1, busy 0, mcu_done 0, err_timeout 0.
REQ-025 err_timeout SHALL clear only on reset_n.

Structure
REQ-026 Package jpeg_seq_pkg SHALL hold FSM state enum, comp_id constants, and 444/420 schedule tables.
REQ-027 Sub-module jpeg_mcu_schedule SHALL map (mode, block index) to comp_id and last-block flag.

Verification
REQ-028 Default params, pix_valid always high from cycle 0: accepts cycles 0-63; dct_enable 64; dct_end_enable 69; matrix_row r on 70+2r..71+2r; zigzag_input_enable 71,73,...,85; zigzag_enable 86; huffman_start 87; huffman_done at 90 -> pix_ready high at 91.
REQ-029 mode_420=0, three blocks: comp_id 0,1,2; is_luminance 1,0,0; mcu_done once after third huffman_done; fourth block comp_id 0.
REQ-030 mode_420=1, toggled to 0 during block 2: six blocks Y,Y,Y,Y,Cb,Cr; mcu_done after sixth.
REQ-031 huffman_done never asserted: err_timeout rises after 1024 HUFF_WAIT cycles, FSM returns to FILL, next block comp_id advances.
REQ-032 abort at cycle 75 (QUANT) with pix_valid high: no strobes in cycle 75, FILL cycle 76, comp_id 0, first accept at 76.
REQ-033 reset_n low mid-DCT_WAIT: all outputs at reset values immediately, without a clock edge.
